// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (640x480@60 by default) from the system
// clock. A divider produces one counter advance every CLK_DIV clocks; x/y and
// every decoded output are registered and change together on that edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_pixels,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_blank_n,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic             SYNC_ON  = 1'(SYNC_POL);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vclk_q, vclk_d;
  logic             pix_en_q, pix_en_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             advance;

  // Next-state: counters step on the advance edge and all decodes are taken
  // from the next counter values so they line up with x/y with no lag.
  always_comb begin
    advance = (div_q == DIV_LAST);
    div_d   = advance ? '0 : div_q + DIV_W'(1);

    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    active_d = active_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (advance) begin
      active_d = (x_d < H_ACT) && (y_d < V_ACT);
      hsync_d  = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
      vsync_d  = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    end

    pix_en_d      = advance;
    line_start_d  = advance && (x_d == 10'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);

    // Falls with the new pixel, rises mid-pixel once data has settled.
    vclk_d = vclk_q;
    if (advance) begin
      vclk_d = 1'b0;
    end else if (div_d == DIV_HALF) begin
      vclk_d = 1'b1;
    end
  end

  // State and output registers; reset parks the counters on the last pixel
  // so the first advance lands on (0,0) with a clean frame_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      active_q      <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      vclk_q        <= 1'b1;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vclk_q        <= vclk_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign active_pixels = active_q;
  assign vga_blank_n   = active_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign vga_clk       = vclk_q;
  assign pix_en        = pix_en_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: reduced raster geometry with an odd divider and
// active-high syncs. Expected outputs per clk come from a closed-form model
// (clk edges since reset release -> pixel index -> x, y and decodes).
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 12, VF = 2, VS = 3, VB = 4;
  localparam int CD = 3;
  localparam int SP = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CD;
  localparam logic SPB = 1'(SP);

  typedef logic [27:0] obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x, y;
  logic       active_pixels, hsync, vsync, vga_blank_n, vga_clk;
  logic       pix_en, line_start, frame_start;
  obs_t       dut_vec;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;
  int   k          = 0;
  int   act_cnt    = 0;
  bit   full_frame = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .SYNC_POL(SP)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .active_pixels(active_pixels), .hsync(hsync), .vsync(vsync),
    .vga_blank_n(vga_blank_n), .vga_clk(vga_clk), .pix_en(pix_en),
    .line_start(line_start), .frame_start(frame_start)
  );

  assign dut_vec = {x, y, active_pixels, hsync, vsync, vga_blank_n,
                    vga_clk, pix_en, line_start, frame_start};

  function automatic obs_t reset_vec();
    return {10'(HT - 1), 10'(VT - 1), 1'b0, ~SPB, ~SPB, 1'b0, 1'b1, 3'b000};
  endfunction

  // Outputs visible after the k-th rising edge since reset release.
  function automatic obs_t model(int kk);
    int n, phase, p, xi, yi;
    logic act, hs, vs, vc, pe, ls, fs;
    n     = kk / CD;
    phase = kk % CD;
    if (kk == 0 || n == 0) return reset_vec();
    p   = n - 1;
    xi  = p % HT;
    yi  = (p / HT) % VT;
    act = (xi < HA) && (yi < VA);
    hs  = (xi >= HA + HF && xi < HA + HF + HS) ? SPB : ~SPB;
    vs  = (yi >= VA + VF && yi < VA + VF + VS) ? SPB : ~SPB;
    vc  = (phase >= CD / 2);
    pe  = (phase == 0);
    ls  = pe && (xi == 0);
    fs  = ls && (yi == 0);
    return {10'(xi), 10'(yi), act, hs, vs, act, vc, pe, ls, fs};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s cycle=%0d got x=%0d y=%0d flags=%b want x=%0d y=%0d flags=%b",
               name, cycle, got[27:18], got[17:8], got[7:0],
               want[27:18], want[17:8], want[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, want);
    end
  endtask

  // Stimulus side: one model entry per rising edge.
  task automatic step();
    @(posedge clk);
    cycle++;
    if (rst) k++;
    else k = 0;
    exp_q.push_back(rst ? model(k) : reset_vec());
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Reset changes land mid-low-phase; assertion is checked before any edge.
  task automatic set_rst(input logic v);
    @(negedge clk);
    #2;
    rst = v;
    if (!v) begin
      #1;
      check("async_reset", dut_vec, reset_vec());
      $display("reset asserted at cycle %0d", cycle);
    end else begin
      $display("reset released at cycle %0d", cycle);
    end
  endtask

  // Monitor: compare every presented cycle and count active pixels per frame.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", dut_vec, e);
    end
    if (!rst) begin
      full_frame = 1'b0;
      act_cnt    = 0;
    end else begin
      if (frame_start) begin
        if (full_frame) check_int("active_per_frame", act_cnt, HA * VA);
        $display("frame_start at cycle %0d active_count=%0d", cycle, act_cnt);
        full_frame = 1'b1;
        act_cnt    = 0;
      end
      if (pix_en && active_pixels) act_cnt++;
    end
  end

  initial begin
    rst = 1'b0;
    run(3);
    set_rst(1'b1);
    run(2 * FRAME_CLK + 50);
    for (int i = 0; i < 5; i++) begin
      run($urandom_range(40, 1800));
      set_rst(1'b0);
      run($urandom_range(1, 4));
      set_rst(1'b1);
    end
    run(FRAME_CLK + 20);
    @(negedge clk);
    #1;
    check_int("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA raster timing from the 50 MHz system clock. It produces the pixel coordinates (x, y) and the active_pixels qualifier consumed by start_screen_renderer and the other screen renderers. It also drives hsync, vsync, blank and the DAC pixel clock to the board's VGA pins. All pixel-rate logic runs on clk, gated by an internal pixel-enable divider.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel; must be >= 2
SYNC_POL, 0, asserted level of hsync/vsync (0 = negative sync)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset; asynchronous, active-low
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
active_pixels  output  1  high while x < H_ACTIVE and y < V_ACTIVE
hsync  output  1  horizontal sync, asserted at level SYNC_POL
vsync  output  1  vertical sync, asserted at level SYNC_POL
vga_blank_n  output  1  equals active_pixels
vga_clk  output  1  DAC pixel clock, period CLK_DIV clk cycles
pix_en  output  1  one-clk pulse on every counter advance
line_start  output  1  one-clk pulse when x advances to 0
frame_start  output  1  one-clk pulse when x and y both advance to 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults). Both totals must be <= 1024.
- Reset (rst low, asynchronous) sets the following, all of which hold while rst is low:
  - div = 0
  - x = H_TOTAL-1, y = V_TOTAL-1
  - active_pixels = 0, vga_blank_n = 0
  - hsync = vsync = ~SYNC_POL
  - vga_clk = 1
  - pix_en = line_start = frame_start = 0
- Divider: div increments every clk edge. When div == CLK_DIV-1 it wraps to 0 and that edge is the "advance edge".
  - The first advance edge is the CLK_DIV-th rising clk after rst deasserts.
- On the advance edge:
  - x <= (x == H_TOTAL-1) ? 0 : x+1.
  - y advances only when x wraps: y <= (y == V_TOTAL-1) ? 0 : y+1.
- The first advance after reset therefore lands on (0,0): frame_start = 1 and line_start = 1.
- Registered outputs: active_pixels, hsync, vsync, vga_blank_n, line_start and frame_start are registers. On each advance edge they are loaded from the *next* counter values, so they always agree with the x and y currently presented. Zero latency relative to x/y; no combinational decode reaches a pin.
- Decode rules:
  - hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491], across whole lines.
- Pulses:
  - pix_en, line_start and frame_start are high for exactly the one clk following the advance edge, and low otherwise.
  - frame_start implies line_start.
- vga_clk is registered:
  - driven to 0 on the advance edge;
  - driven to 1 on the edge where div becomes CLK_DIV/2 (integer division).
  - Its rising edge therefore falls mid-pixel, after the data has settled.
- Between advance edges every output holds its value.
- Reset asserted mid-frame forces the reset values immediately. Timing restarts cleanly, with no partial pulse.

Test Plan:
- Reset release, CLK_DIV=2 -> first pix_en and frame_start one clk after the 2nd rising edge; at that point x=0, y=0, active_pixels=1, hsync=vsync=1.
- Free-run one line -> x steps 0..799 with one step every 2 clk, then wraps to 0 and y increments; active_pixels falls at x=640; hsync=0 exactly for x=656..751 (96 pixels = 192 clk); line_start period = 1600 clk.
- Free-run a full frame -> vsync=0 exactly for y=490..491 (1600 pixels); active_pixels never high for y >= 480; frame_start period = 840000 clk; counted active pixels per frame = 307200.
- vga_clk check -> period 2 clk, 50% duty; falls on each advance edge; x/y stable across every vga_clk rising edge.
- Assert rst at x=300, y=200 for 3 clk, then release -> outputs take the reset values asynchronously (before the next clk edge); the next frame_start arrives 2 clk after release with no spurious line_start.
- SYNC_POL=1, CLK_DIV=4 -> syncs are active-high over the same x/y ranges; pix_en period = 4 clk; vga_clk high for 2 clk and low for 2 clk.
